// File: rtl/mul_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_issue_arbiter
// Brief    : Round-robin, credit-limited issue of multiply operations from
//            several reservation stations into one shared mul unit. Tracks
//            the tag/source of every in-flight operation and buffers results
//            for a back-pressured common data bus, with pipeline flush.
// Revision : 1.0 - initial release
// ============================================================================
module mul_issue_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 6,
    parameter int DEPTH   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*32-1:0]      req_pc_i,
    input  logic [NUM_REQ*32-1:0]      req_inst_i,
    input  logic [NUM_REQ*32-1:0]      req_rs1_value_i,
    input  logic [NUM_REQ*32-1:0]      req_rs2_value_i,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag_i,
    output logic                       mul_request_o,
    output logic [31:0]                mul_pc_o,
    output logic [31:0]                mul_inst_o,
    output logic [31:0]                mul_rs1_value_o,
    output logic [31:0]                mul_rs2_value_o,
    input  logic                       mul_writeback_valid_i,
    input  logic [31:0]                mul_writeback_value_i,
    output logic                       cdb_valid_o,
    input  logic                       cdb_ready_i,
    output logic [TAG_W-1:0]           cdb_tag_o,
    output logic [$clog2(NUM_REQ)-1:0] cdb_src_o,
    output logic [31:0]                cdb_value_o,
    input  logic                       flush_i,
    output logic                       busy_o,
    output logic                       error_o
);

    localparam int c_SRC_W = $clog2(NUM_REQ);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_OCC_W = c_CNT_W + 1;

    // Round-robin pointer: index that currently has highest priority
    logic [c_SRC_W-1:0] r_prio;

    // Tag FIFO: one entry per operation issued but not yet written back
    logic [DEPTH-1:0]   r_tf_live;
    logic [TAG_W-1:0]   r_tf_tag [DEPTH];
    logic [c_SRC_W-1:0] r_tf_src [DEPTH];
    logic [c_PTR_W-1:0] r_tf_rd;
    logic [c_PTR_W-1:0] r_tf_wr;
    logic [c_CNT_W-1:0] r_tf_cnt;

    // Result FIFO: completed results waiting for the CDB
    logic [TAG_W-1:0]   r_rf_tag [DEPTH];
    logic [c_SRC_W-1:0] r_rf_src [DEPTH];
    logic [31:0]        r_rf_val [DEPTH];
    logic [c_PTR_W-1:0] r_rf_rd;
    logic [c_PTR_W-1:0] r_rf_wr;
    logic [c_CNT_W-1:0] r_rf_cnt;

    // Issue register towards the multiplier
    logic               r_mul_req;
    logic [31:0]        r_mul_pc;
    logic [31:0]        r_mul_inst;
    logic [31:0]        r_mul_rs1;
    logic [31:0]        r_mul_rs2;
    logic               r_error;

    logic [c_OCC_W-1:0] w_occ;
    logic               w_credit;
    logic               w_found;
    logic [c_SRC_W-1:0] w_idx;
    logic [c_SRC_W-1:0] w_win;
    logic               w_grant;
    logic [TAG_W-1:0]   w_grant_tag;
    logic               w_tf_empty;
    logic               w_wb_pop;
    logic               w_head_live;
    logic               w_rf_push;
    logic               w_rf_pop;
    logic               w_rf_nonempty;

    // Credit: every operation holds one slot from grant until it leaves on
    // the CDB or is dropped, so the two FIFOs can never overflow.
    assign w_occ    = c_OCC_W'(r_tf_cnt) + c_OCC_W'(r_rf_cnt);
    assign w_credit = (w_occ < c_OCC_W'(DEPTH));

    // Pick the first valid requester scanning upward from the priority pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = c_SRC_W'((int'(r_prio) + k) % NUM_REQ);
            if (!w_found && req_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Ready is held low while reset is asserted so nothing is accepted then
    assign w_grant     = reset_ni & w_found & w_credit & ~flush_i;
    assign req_ready_o = w_grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_win) : '0;
    assign w_grant_tag = req_tag_i[w_win*TAG_W +: TAG_W];

    // Writeback retires the tag FIFO head; an empty FIFO makes it a protocol error
    assign w_tf_empty    = (r_tf_cnt == '0);
    assign w_wb_pop      = mul_writeback_valid_i & ~w_tf_empty;
    assign w_head_live   = r_tf_live[r_tf_rd];
    assign w_rf_push     = w_wb_pop & w_head_live & ~flush_i;
    assign w_rf_nonempty = (r_rf_cnt != '0);
    assign w_rf_pop      = w_rf_nonempty & cdb_ready_i & ~flush_i;

    // Tag FIFO pointers, count and live bits; flush kills every entry
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_tf_live <= '0;
            r_tf_rd   <= '0;
            r_tf_wr   <= '0;
            r_tf_cnt  <= '0;
        end else begin
            if (w_grant) begin
                r_tf_wr <= r_tf_wr + c_PTR_W'(1);
            end
            if (w_wb_pop) begin
                r_tf_rd <= r_tf_rd + c_PTR_W'(1);
            end
            r_tf_cnt <= r_tf_cnt + c_CNT_W'(w_grant) - c_CNT_W'(w_wb_pop);
            if (flush_i) begin
                r_tf_live <= '0;
            end else if (w_grant) begin
                r_tf_live[r_tf_wr] <= 1'b1;
            end
        end
    end

    // Result FIFO pointers and count; flush discards all buffered results
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rf_rd  <= '0;
            r_rf_wr  <= '0;
            r_rf_cnt <= '0;
        end else if (flush_i) begin
            r_rf_rd  <= '0;
            r_rf_wr  <= '0;
            r_rf_cnt <= '0;
        end else begin
            if (w_rf_push) begin
                r_rf_wr <= r_rf_wr + c_PTR_W'(1);
            end
            if (w_rf_pop) begin
                r_rf_rd <= r_rf_rd + c_PTR_W'(1);
            end
            r_rf_cnt <= r_rf_cnt + c_CNT_W'(w_rf_push) - c_CNT_W'(w_rf_pop);
        end
    end

    // FIFO payload storage; validity is tracked by the counts above
    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_tf_tag[r_tf_wr] <= w_grant_tag;
            r_tf_src[r_tf_wr] <= w_win;
        end
        if (w_rf_push) begin
            r_rf_tag[r_rf_wr] <= r_tf_tag[r_tf_rd];
            r_rf_src[r_rf_wr] <= r_tf_src[r_tf_rd];
            r_rf_val[r_rf_wr] <= mul_writeback_value_i;
        end
    end

    // Issue register, round-robin pointer update and sticky error flag
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_mul_req  <= 1'b0;
            r_mul_pc   <= '0;
            r_mul_inst <= '0;
            r_mul_rs1  <= '0;
            r_mul_rs2  <= '0;
            r_prio     <= '0;
            r_error    <= 1'b0;
        end else begin
            r_mul_req <= w_grant;
            if (w_grant) begin
                r_mul_pc   <= req_pc_i[w_win*32 +: 32];
                r_mul_inst <= req_inst_i[w_win*32 +: 32];
                r_mul_rs1  <= req_rs1_value_i[w_win*32 +: 32];
                r_mul_rs2  <= req_rs2_value_i[w_win*32 +: 32];
                r_prio     <= c_SRC_W'((int'(w_win) + 1) % NUM_REQ);
            end
            if (mul_writeback_valid_i && w_tf_empty) begin
                r_error <= 1'b1;
            end
        end
    end

    assign mul_request_o   = r_mul_req;
    assign mul_pc_o        = r_mul_pc;
    assign mul_inst_o      = r_mul_inst;
    assign mul_rs1_value_o = r_mul_rs1;
    assign mul_rs2_value_o = r_mul_rs2;

    // CDB shows the result FIFO head; payload is forced to zero when empty
    assign cdb_valid_o = w_rf_nonempty;
    assign cdb_tag_o   = w_rf_nonempty ? r_rf_tag[r_rf_rd] : '0;
    assign cdb_src_o   = w_rf_nonempty ? r_rf_src[r_rf_rd] : '0;
    assign cdb_value_o = w_rf_nonempty ? r_rf_val[r_rf_rd] : '0;

    assign busy_o  = ~w_tf_empty | w_rf_nonempty;
    assign error_o = r_error;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_issue_arbiter
// Brief    : Directed self-checking bench for mul_issue_arbiter with a
//            queue-based reference model and a latency-programmable mul.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_issue_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TAG_W   = 6;
    localparam int DEPTH   = 4;

    logic                     clk = 1'b0;
    logic                     reset_ni;
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*32-1:0]    req_pc_i;
    logic [NUM_REQ*32-1:0]    req_inst_i;
    logic [NUM_REQ*32-1:0]    req_rs1_value_i;
    logic [NUM_REQ*32-1:0]    req_rs2_value_i;
    logic [NUM_REQ*TAG_W-1:0] req_tag_i;
    logic                     mul_request_o;
    logic [31:0]              mul_pc_o;
    logic [31:0]              mul_inst_o;
    logic [31:0]              mul_rs1_value_o;
    logic [31:0]              mul_rs2_value_o;
    logic                     mul_writeback_valid_i;
    logic [31:0]              mul_writeback_value_i;
    logic                     cdb_valid_o;
    logic                     cdb_ready_i;
    logic [TAG_W-1:0]         cdb_tag_o;
    logic [0:0]               cdb_src_o;
    logic [31:0]              cdb_value_o;
    logic                     flush_i;
    logic                     busy_o;
    logic                     error_o;

    always #5 clk = ~clk;

    mul_issue_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk_i                 (clk),
        .reset_ni              (reset_ni),
        .req_valid_i           (req_valid_i),
        .req_ready_o           (req_ready_o),
        .req_pc_i              (req_pc_i),
        .req_inst_i            (req_inst_i),
        .req_rs1_value_i       (req_rs1_value_i),
        .req_rs2_value_i       (req_rs2_value_i),
        .req_tag_i             (req_tag_i),
        .mul_request_o         (mul_request_o),
        .mul_pc_o              (mul_pc_o),
        .mul_inst_o            (mul_inst_o),
        .mul_rs1_value_o       (mul_rs1_value_o),
        .mul_rs2_value_o       (mul_rs2_value_o),
        .mul_writeback_valid_i (mul_writeback_valid_i),
        .mul_writeback_value_i (mul_writeback_value_i),
        .cdb_valid_o           (cdb_valid_o),
        .cdb_ready_i           (cdb_ready_i),
        .cdb_tag_o             (cdb_tag_o),
        .cdb_src_o             (cdb_src_o),
        .cdb_value_o           (cdb_value_o),
        .flush_i               (flush_i),
        .busy_o                (busy_o),
        .error_o               (error_o)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; logic [31:0] rs1; logic [31:0] rs2; logic [TAG_W-1:0] tag; } op_t;
    typedef struct { bit live; logic [TAG_W-1:0] tag; int src; } inflight_t;
    typedef struct { logic [TAG_W-1:0] tag; int src; logic [31:0] value; } result_t;
    typedef struct { int due; logic [31:0] value; } mulop_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mul_lat = 3;
    bit cdb_rdy = 1'b1;

    // Requester operation queues (owned by the stimulus process)
    op_t rq [NUM_REQ][$];

    // Reference model state (owned by the compare process)
    int                 m_prio = 0;
    inflight_t          m_tagq [$];
    result_t            m_resq [$];
    bit                 m_iss = 1'b0;
    logic [31:0]        m_pc = '0, m_inst = '0, m_rs1 = '0, m_rs2 = '0;
    bit                 m_err = 1'b0;
    mulop_t             mulq [$];
    logic [NUM_REQ-1:0] acc_mask = '0;
    bit                 nxt_wb_v = 1'b0;
    logic [31:0]        nxt_wb_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_op(input int r, input logic [TAG_W-1:0] tag, input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.pc   = 32'h1000 + 32'(tag) * 4;
        o.inst = 32'h0200_0033 | (32'(tag) << 7);
        o.rs1  = a;
        o.rs2  = b;
        o.tag  = tag;
        rq[r].push_back(o);
    endtask

    // Advance one clock: retire accepted ops and drive the next cycle's inputs
    task automatic step(input bit fwb = 1'b0);
        op_t o;
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (acc_mask[r] && rq[r].size() != 0) void'(rq[r].pop_front());
            if (rq[r].size() != 0) begin
                o = rq[r][0];
                req_valid_i[r]                 = 1'b1;
                req_pc_i[r*32 +: 32]           = o.pc;
                req_inst_i[r*32 +: 32]         = o.inst;
                req_rs1_value_i[r*32 +: 32]    = o.rs1;
                req_rs2_value_i[r*32 +: 32]    = o.rs2;
                req_tag_i[r*TAG_W +: TAG_W]    = o.tag;
            end else begin
                req_valid_i[r]                 = 1'b0;
                req_pc_i[r*32 +: 32]           = '0;
                req_inst_i[r*32 +: 32]         = '0;
                req_rs1_value_i[r*32 +: 32]    = '0;
                req_rs2_value_i[r*32 +: 32]    = '0;
                req_tag_i[r*TAG_W +: TAG_W]    = '0;
            end
        end
        flush_i               = 1'b0;
        cdb_ready_i           = cdb_rdy;
        mul_writeback_valid_i = nxt_wb_v | fwb;
        mul_writeback_value_i = fwb ? 32'hDEAD_BEEF : nxt_wb_val;
    endtask

    // Compare DUT against the model every cycle, then advance the model
    always @(negedge clk) begin
        int occ;
        int g;
        logic [NUM_REQ-1:0] exp_rdy;
        bit cpop;
        inflight_t e;
        mulop_t mo;
        if (!reset_ni) begin
            chk("rst_ready", req_ready_o, 0);
            chk("rst_mul_req", mul_request_o, 0);
            chk("rst_mul_pc", mul_pc_o, 0);
            chk("rst_mul_rs1", mul_rs1_value_o, 0);
            chk("rst_cdb_valid", cdb_valid_o, 0);
            chk("rst_cdb_tag", cdb_tag_o, 0);
            chk("rst_cdb_value", cdb_value_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_error", error_o, 0);
            m_prio = 0; m_tagq.delete(); m_resq.delete();
            m_iss = 1'b0; m_pc = '0; m_inst = '0; m_rs1 = '0; m_rs2 = '0; m_err = 1'b0;
            mulq.delete(); nxt_wb_v = 1'b0; nxt_wb_val = '0; acc_mask = '0;
        end else begin
            occ = m_tagq.size() + m_resq.size();
            g = -1;
            if (!flush_i && occ < DEPTH) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (g < 0 && req_valid_i[(m_prio + k) % NUM_REQ]) g = (m_prio + k) % NUM_REQ;
                end
            end
            exp_rdy = (g >= 0) ? NUM_REQ'(1 << g) : '0;

            chk("ready", req_ready_o, exp_rdy);
            chk("mul_request", mul_request_o, m_iss);
            chk("mul_pc", mul_pc_o, m_pc);
            chk("mul_inst", mul_inst_o, m_inst);
            chk("mul_rs1", mul_rs1_value_o, m_rs1);
            chk("mul_rs2", mul_rs2_value_o, m_rs2);
            chk("cdb_valid", cdb_valid_o, m_resq.size() != 0);
            if (m_resq.size() != 0) begin
                chk("cdb_tag", cdb_tag_o, m_resq[0].tag);
                chk("cdb_src", cdb_src_o, m_resq[0].src);
                chk("cdb_value", cdb_value_o, m_resq[0].value);
            end
            chk("busy", busy_o, occ != 0);
            chk("error", error_o, m_err);

            cpop = (m_resq.size() != 0) && cdb_ready_i && !flush_i;
            if (flush_i) begin
                m_resq.delete();
                foreach (m_tagq[i]) m_tagq[i].live = 1'b0;
            end else if (cpop) begin
                void'(m_resq.pop_front());
            end
            if (mul_writeback_valid_i) begin
                if (m_tagq.size() == 0) m_err = 1'b1;
                else begin
                    e = m_tagq.pop_front();
                    if (e.live) m_resq.push_back('{e.tag, e.src, mul_writeback_value_i});
                end
            end
            m_iss = (g >= 0);
            if (g >= 0) begin
                m_pc  = req_pc_i[g*32 +: 32];
                m_inst = req_inst_i[g*32 +: 32];
                m_rs1 = req_rs1_value_i[g*32 +: 32];
                m_rs2 = req_rs2_value_i[g*32 +: 32];
                m_tagq.push_back('{1'b1, req_tag_i[g*TAG_W +: TAG_W], g});
                m_prio = (g + 1) % NUM_REQ;
            end
            acc_mask = exp_rdy;

            if (mul_request_o) mulq.push_back('{cyc + mul_lat, mul_rs1_value_o * mul_rs2_value_o});
            nxt_wb_v = 1'b0;
            if (mulq.size() != 0 && mulq[0].due <= cyc + 1) begin
                mo = mulq.pop_front();
                nxt_wb_v   = 1'b1;
                nxt_wb_val = mo.value;
            end
        end
    end

    initial begin
        int ngr;
        int n;
        reset_ni = 1'b0;
        req_valid_i = '0; req_pc_i = '0; req_inst_i = '0;
        req_rs1_value_i = '0; req_rs2_value_i = '0; req_tag_i = '0;
        mul_writeback_valid_i = 1'b0; mul_writeback_value_i = '0;
        cdb_ready_i = 1'b0; flush_i = 1'b0;
        repeat (3) step();
        reset_ni = 1'b1;
        step();

        // Single operation, mul latency 3: 6*7 on tag 5 from requester 0
        mul_lat = 3; cdb_rdy = 1'b1;
        add_op(0, 6'd5, 32'd6, 32'd7);
        step(); #1;
        chk("single_grant", req_ready_o, 2'b01);
        step(); #1;
        chk("single_issue", mul_request_o, 1);
        chk("single_rs1", mul_rs1_value_o, 6);
        chk("single_rs2", mul_rs2_value_o, 7);
        step(); #1;
        chk("single_issue_once", mul_request_o, 0);
        for (int k = 0; k < 2; k++) begin
            step(); #1;
            chk("single_cdb_early", cdb_valid_o, 0);
        end
        step(); #1;
        chk("single_cdb_valid", cdb_valid_o, 1);
        chk("single_cdb_tag", cdb_tag_o, 5);
        chk("single_cdb_src", cdb_src_o, 0);
        chk("single_cdb_value", cdb_value_o, 42);
        step(); #1;
        chk("single_cdb_popped", cdb_valid_o, 0);

        // Arbitration: both requesters busy for 8 cycles, mul latency 1
        mul_lat = 1;
        for (int i = 0; i < 4; i++) begin
            add_op(0, 6'(16 + i), 32'(3 + i), 32'(100 + i));
            add_op(1, 6'(32 + i), 32'(7 + i), 32'(200 + i));
        end
        for (int k = 0; k < 8; k++) begin
            step(); #1;
            chk("arb_ready", req_ready_o, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k > 0) chk("arb_issue", mul_request_o, 1);
        end
        step(); #1;
        chk("arb_issue_last", mul_request_o, 1);
        repeat (6) step();

        // Credit limit: CDB stalled, 6 ops offered, only DEPTH granted
        mul_lat = 2; cdb_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            add_op(0, 6'(40 + i), 32'(11 + i), 32'(13 + i));
            add_op(1, 6'(48 + i), 32'(17 + i), 32'(19 + i));
        end
        ngr = 0;
        for (int k = 0; k < 10; k++) begin
            step(); #1;
            if (req_ready_o != '0) ngr++;
        end
        chk("credit_grants", ngr, 4);
        chk("credit_blocked", req_ready_o, 0);
        chk("credit_full_cdb", cdb_valid_o, 1);
        cdb_rdy = 1'b1;
        step(); #1;
        chk("credit_pop_no_grant", req_ready_o, 0);
        step(); #1;
        chk("credit_return", req_ready_o != '0, 1);
        repeat (12) step();

        // Flush with 3 in flight and 1 buffered result
        mul_lat = 6; cdb_rdy = 1'b0;
        add_op(0, 6'd20, 32'd2, 32'd3);
        add_op(1, 6'd21, 32'd4, 32'd5);
        add_op(0, 6'd22, 32'd6, 32'd7);
        add_op(1, 6'd23, 32'd8, 32'd9);
        n = 0;
        do begin
            step(); #1; n++;
        end while (cdb_valid_o !== 1'b1 && n < 20);
        chk("flush_setup_valid", cdb_valid_o, 1);
        chk("flush_setup_busy", busy_o, 1);
        flush_i = 1'b1;
        step(); #1;
        chk("flush_cdb_drop", cdb_valid_o, 0);
        chk("flush_busy_a", busy_o, 1);
        step(); #1;
        chk("flush_cdb_hold0_a", cdb_valid_o, 0);
        chk("flush_busy_b", busy_o, 1);
        step(); #1;
        chk("flush_cdb_hold0_b", cdb_valid_o, 0);
        chk("flush_busy_clear", busy_o, 0);

        mul_lat = 3; cdb_rdy = 1'b1;
        add_op(1, 6'd9, 32'd11, 32'd13);
        n = 0;
        do begin
            step(); #1; n++;
        end while (cdb_valid_o !== 1'b1 && n < 15);
        chk("post_flush_valid", cdb_valid_o, 1);
        chk("post_flush_tag", cdb_tag_o, 9);
        chk("post_flush_src", cdb_src_o, 1);
        chk("post_flush_value", cdb_value_o, 143);
        repeat (3) step();

        // Protocol error: writeback with nothing in flight
        step(1'b1); #1;
        chk("err_not_yet", error_o, 0);
        step(); #1;
        chk("err_set", error_o, 1);
        chk("err_no_cdb", cdb_valid_o, 0);
        repeat (3) step();
        #1;
        chk("err_sticky", error_o, 1);

        // Asynchronous reset mid-burst with two operations in flight
        add_op(0, 6'd30, 32'd3, 32'd4);
        add_op(0, 6'd31, 32'd5, 32'd6);
        add_op(0, 6'd32, 32'd7, 32'd8);
        step(); step(); step();
        #1;
        chk("burst_busy", busy_o, 1);
        reset_ni = 1'b0;
        #1;
        chk("arst_ready", req_ready_o, 0);
        chk("arst_mul_req", mul_request_o, 0);
        chk("arst_mul_rs1", mul_rs1_value_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_error", error_o, 0);
        chk("arst_cdb_valid", cdb_valid_o, 0);
        step(); step();
        reset_ni = 1'b1;
        #1;
        chk("post_reset_ready", req_ready_o, 2'b01);
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
